crank_wheel_gen: RTL and testbench

//  Crank trigger-wheel emulator: synthesises a tooth/gap pulse train (e.g. 60-2) that drives the VR input of the angle generator for bench and HIL testing.

---
 rtl/crank_wheel_gen_if.sv | 10 +
 rtl/crank_wheel_gen.sv | 186 ++++++++++++++++++
 tb/tb_crank_wheel_gen.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/crank_wheel_gen_if.sv
// Register bus control signals shared by the hwag register blocks.
// The 16-bit data lines are a tristate net and stay a plain inout port.
interface crank_wheel_gen_if;
   logic       ssram_we;
   logic       ssram_re;
   logic [7:0] ssram_addr;

   modport master (output ssram_we, ssram_re, ssram_addr);
   modport slave  (input  ssram_we, ssram_re, ssram_addr);
endinterface

// File: rtl/crank_wheel_gen.sv
// Crank trigger-wheel emulator: tooth/gap pulse train with bus-programmable
// period, tooth count, missing teeth, pulse width and polarity.
module crank_wheel_gen #(
   parameter logic [7:0]  BASE_ADDR = 8'h40,
   parameter int unsigned PW        = 24
) (
   input  logic              clk,
   input  logic              rst,
   crank_wheel_gen_if.slave  bus,
   inout  wire  [15:0]       ssram_data,
   output logic              wheel_out,
   output logic              tooth_stb,
   output logic              rev_stb,
   output logic              running
);

   localparam int unsigned NREG = 6;

   typedef enum logic {IDLE, RUN} state_t;

   state_t         state, state_nxt;

   // bus-visible registers
   logic           en, pol;
   logic [15:0]    per_hold;
   logic [PW-1:0]  per_sh;
   logic [7:0]     n_sh, m_sh;
   logic [15:0]    high_sh;

   // active copies, refreshed only at tooth boundaries or while idle
   logic [PW-1:0]  per_a;
   logic [7:0]     n_a, m_a;
   logic [15:0]    high_a;

   logic [PW-1:0]  pcnt, pcnt_nxt;
   logic [7:0]     tidx, tidx_nxt;
   logic           load;
   logic           wheel_nxt, tooth_nxt, rev_nxt;

   logic [7:0]     off;
   logic           hit;
   logic [15:0]    rdata;

   logic [PW-1:0]  p_eff, h_ext, h_eff;
   logic           valid_a, valid_sh, act, wrap;

   // address decode
   assign off = 8'(bus.ssram_addr - BASE_ADDR);
   assign hit = (off < 8'(NREG));

   // read mux; unused bits return zero
   always_comb begin
      rdata = '0;
      case (off)
         8'd0:    rdata = {14'd0, pol, en};
         8'd1:    rdata = per_hold;
         8'd2:    rdata = {8'd0, 8'(per_sh >> 16)};
         8'd3:    rdata = {m_sh, n_sh};
         8'd4:    rdata = high_sh;
         8'd5:    rdata = {7'd0, running, tidx};
         default: rdata = '0;
      endcase
   end

   assign ssram_data = (bus.ssram_re && hit) ? rdata : 16'hzzzz;

   // bus writes into control, holding and shadow registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         en       <= 1'b0;
         pol      <= 1'b0;
         per_hold <= 16'd100;
         per_sh   <= PW'(100);
         n_sh     <= 8'd60;
         m_sh     <= 8'd2;
         high_sh  <= 16'd8;
      end else if (bus.ssram_we && hit) begin
         case (off)
            8'd0: begin
               en  <= ssram_data[0];
               pol <= ssram_data[1];
            end
            8'd1: per_hold <= ssram_data;
            8'd2: per_sh   <= PW'({ssram_data[7:0], per_hold});
            8'd3: begin
               n_sh <= ssram_data[7:0];
               m_sh <= ssram_data[15:8];
            end
            8'd4: high_sh <= ssram_data;
            default: ;
         endcase
      end
   end

   // effective period (min 2), clipped pulse width, config validity, tooth output
   always_comb begin
      p_eff    = (per_a < PW'(2)) ? PW'(2) : per_a;
      h_ext    = PW'(high_a);
      h_eff    = (h_ext >= p_eff) ? (p_eff - PW'(1)) : h_ext;
      valid_a  = (n_a >= 8'd2) && (m_a < n_a);
      valid_sh = (n_sh >= 8'd2) && (m_sh < n_sh);
      act      = (tidx < (n_a - m_a)) && (pcnt < h_eff);
      wrap     = (pcnt == (p_eff - PW'(1)));
   end

   // next state, counters and output values
   always_comb begin
      state_nxt = state;
      pcnt_nxt  = pcnt;
      tidx_nxt  = tidx;
      load      = 1'b0;
      wheel_nxt = pol;
      tooth_nxt = 1'b0;
      rev_nxt   = 1'b0;
      case (state)
         IDLE: begin
            load     = 1'b1;
            pcnt_nxt = '0;
            tidx_nxt = '0;
            if (en && valid_a) begin
               // first tooth starts on this very edge
               state_nxt = RUN;
               wheel_nxt = act ^ pol;
               tooth_nxt = 1'b1;
               rev_nxt   = 1'b1;
               pcnt_nxt  = PW'(1);
            end
         end
         RUN: begin
            if (!en) begin
               state_nxt = IDLE;
               pcnt_nxt  = '0;
               tidx_nxt  = '0;
            end else begin
               wheel_nxt = act ^ pol;
               tooth_nxt = (pcnt == '0);
               rev_nxt   = (pcnt == '0) && (tidx == '0);
               if (wrap) begin
                  load     = 1'b1;
                  pcnt_nxt = '0;
                  // wrap against the tooth count that takes effect now
                  tidx_nxt = (({1'b0, tidx} + 9'd1) >= {1'b0, n_sh}) ? 8'd0 : (tidx + 8'd1);
                  if (!valid_sh) begin
                     state_nxt = IDLE;
                     tidx_nxt  = '0;
                  end
               end else begin
                  pcnt_nxt = pcnt + PW'(1);
               end
            end
         end
      endcase
   end

   // state, counters, active configuration and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         pcnt      <= '0;
         tidx      <= '0;
         per_a     <= PW'(100);
         n_a       <= 8'd60;
         m_a       <= 8'd2;
         high_a    <= 16'd8;
         wheel_out <= 1'b0;
         tooth_stb <= 1'b0;
         rev_stb   <= 1'b0;
         running   <= 1'b0;
      end else begin
         state     <= state_nxt;
         pcnt      <= pcnt_nxt;
         tidx      <= tidx_nxt;
         wheel_out <= wheel_nxt;
         tooth_stb <= tooth_nxt;
         rev_stb   <= rev_nxt;
         running   <= (state_nxt == RUN);
         if (load) begin
            per_a  <= per_sh;
            n_a    <= n_sh;
            m_a    <= m_sh;
            high_a <= high_sh;
         end
      end
   end

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Bench for crank_wheel_gen: directed bus programming, a cycle-accurate
// arithmetic model of the tooth train, and hand-computed spot values.
module tb_crank_wheel_gen;
   localparam logic [7:0] BASE  = 8'h40;
   localparam longint     NEVER = 64'd1 << 40;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   wire  [15:0] ssram_data;
   logic        drv = 1'b0;
   logic [15:0] wdata = '0;
   logic        wheel_out, tooth_stb, rev_stb, running;

   int cyc   = 0;
   int n_cmp = 0;
   int n_bad = 0;

   crank_wheel_gen_if bus ();

   assign ssram_data = drv ? wdata : 16'hzzzz;
   for (genvar i = 0; i < 16; i++) begin : g_pu
      pullup pu (ssram_data[i]);
   end

   crank_wheel_gen #(.BASE_ADDR(BASE), .PW(24)) dut (
      .clk        (clk),
      .rst        (rst),
      .bus        (bus),
      .ssram_data (ssram_data),
      .wheel_out  (wheel_out),
      .tooth_stb  (tooth_stb),
      .rev_stb    (rev_stb),
      .running    (running)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // model: a run that started output cycle m_t0 and stops at m_stop
   bit     m_on   = 1'b0;
   longint m_t0   = NEVER;
   longint m_stop = 0;
   int     m_p = 100, m_n = 60, m_m = 2, m_h = 8;
   bit     m_pol = 1'b0;

   function automatic void set_cfg(input int period, input int high, input int n, input int m, input bit p);
      m_p   = (period < 2) ? 2 : period;
      m_h   = (high > m_p - 1) ? m_p - 1 : high;
      m_n   = n;
      m_m   = m;
      m_pol = p;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, got, exp, cyc);
      end
   endtask

   // per-cycle comparison against the model
   longint mc, mpc, mti;
   logic   e_w, e_t, e_r, e_run;
   always @(negedge clk) begin
      if (m_on && rst) begin
         if (cyc >= m_t0 && cyc < m_stop) begin
            mc    = longint'(cyc) - m_t0;
            mpc   = mc % m_p;
            mti   = (mc / m_p) % m_n;
            e_w   = ((mti < m_n - m_m) && (mpc < m_h)) ^ m_pol;
            e_t   = (mpc == 0);
            e_r   = (mpc == 0) && (mti == 0);
            e_run = 1'b1;
         end else begin
            e_w = m_pol; e_t = 1'b0; e_r = 1'b0; e_run = 1'b0;
         end
         chk("model_wheel",   wheel_out, e_w);
         chk("model_tooth",   tooth_stb, e_t);
         chk("model_rev",     rev_stb,   e_r);
         chk("model_running", running,   e_run);
      end
   end

   task automatic bus_write(input logic [7:0] a, input logic [15:0] d);
      @(negedge clk);
      bus.ssram_we = 1'b1; bus.ssram_addr = a; wdata = d; drv = 1'b1;
      @(negedge clk);
      bus.ssram_we = 1'b0; drv = 1'b0;
   endtask

   task automatic bus_read(input logic [7:0] a, output logic [15:0] d);
      @(negedge clk);
      bus.ssram_re = 1'b1; bus.ssram_addr = a;
      #2 d = ssram_data;
      bus.ssram_re = 1'b0;
   endtask

   task automatic read_chk(input string nm, input logic [7:0] a, input logic [15:0] exp);
      logic [15:0] d;
      bus_read(a, d);
      chk(nm, d, exp);
   endtask

   task automatic enable_run();
      bus_write(BASE, {14'd0, m_pol, 1'b1});
      m_t0   = longint'(cyc) + 1;
      m_stop = NEVER;
   endtask

   task automatic disable_run();
      bus_write(BASE, {14'd0, m_pol, 1'b0});
      m_stop = longint'(cyc) + 1;
   endtask

   // sel: 0 wheel_out, 1 tooth_stb, 2 rev_stb
   task automatic wait_until(input int sel, input logic val, input int budget, output int at);
      logic s;
      at = -1;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         s = (sel == 0) ? wheel_out : (sel == 1) ? tooth_stb : rev_stb;
         if (s == val) begin
            at = cyc;
            break;
         end
      end
      chk("wait_event_seen", (at >= 0) ? 32'd1 : 32'd0, 32'd1);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi, th, rv, ta, t1, t2, t3;
      logic [15:0] d;
      bus.ssram_we = 1'b0; bus.ssram_re = 1'b0; bus.ssram_addr = '0;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_wheel", wheel_out, 0);
      chk("rst_tooth", tooth_stb, 0);
      chk("rst_rev", rev_stb, 0);
      chk("rst_running", running, 0);
      rst = 1'b1;
      set_cfg(100, 8, 60, 2, 0);
      m_on = 1'b1;

      // register reset values and hi-Z behaviour
      read_chk("rd_ctrl_rst",  BASE + 8'd0, 16'h0000);
      read_chk("rd_perl_rst",  BASE + 8'd1, 16'd100);
      read_chk("rd_perh_rst",  BASE + 8'd2, 16'h0000);
      read_chk("rd_teeth_rst", BASE + 8'd3, 16'h023C);
      read_chk("rd_high_rst",  BASE + 8'd4, 16'h0008);
      read_chk("rd_stat_rst",  BASE + 8'd5, 16'h0000);
      read_chk("hiz_3f", 8'h3F, 16'hFFFF);
      read_chk("hiz_46", 8'h46, 16'hFFFF);
      read_chk("hiz_ff", 8'hFF, 16'hFFFF);
      @(negedge clk);
      bus.ssram_addr = BASE + 8'd3;
      #2 chk("hiz_re_low", ssram_data, 16'hFFFF);
      bus_write(BASE + 8'd1, 16'h1234);
      bus_write(BASE + 8'd2, 16'h0056);
      read_chk("rd_perl_pat", BASE + 8'd1, 16'h1234);
      read_chk("rd_perh_pat", BASE + 8'd2, 16'h0056);

      // 6-2 wheel, P=10, HIGH=4
      bus_write(BASE + 8'd3, 16'h0206);
      bus_write(BASE + 8'd1, 16'd10);
      bus_write(BASE + 8'd2, 16'd0);
      bus_write(BASE + 8'd4, 16'd4);
      set_cfg(10, 4, 6, 2, 0);
      read_chk("rd_teeth", BASE + 8'd3, 16'h0206);
      read_chk("rd_high",  BASE + 8'd4, 16'h0004);
      read_chk("rd_perl",  BASE + 8'd1, 16'd10);
      enable_run();
      hi = 0; th = 0; rv = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i == 0) begin
            chk("t1_first_wheel", wheel_out, 1);
            chk("t1_first_rev", rev_stb, 1);
            chk("t1_first_run", running, 1);
         end
         hi += int'(wheel_out); th += int'(tooth_stb); rv += int'(rev_stb);
      end
      chk("t1_high_per_rev", hi, 16);
      chk("t1_teeth_per_rev", th, 6);
      chk("t1_revs", rv, 1);
      read_chk("rd_ctrl_en", BASE, 16'h0001);

      // clear EN mid-pulse, then restart
      wait_until(2, 1'b1, 100, ta);
      disable_run();
      chk("t3_still_high", wheel_out, 1);
      @(negedge clk);
      chk("t3_wheel_pol", wheel_out, 0);
      chk("t3_running_off", running, 0);
      read_chk("t3_stat_idle", BASE + 8'd5, 16'h0000);
      enable_run();
      @(negedge clk);
      chk("t3_restart_rev", rev_stb, 1);
      repeat (24) @(negedge clk);
      read_chk("t3_stat_run", BASE + 8'd5, 16'h0102);

      // period change mid-tooth
      m_on = 1'b0;
      wait_until(1, 1'b1, 40, ta);
      bus_write(BASE + 8'd1, 16'd20);
      bus_write(BASE + 8'd2, 16'd0);
      wait_until(1, 1'b1, 40, t1);
      wait_until(1, 1'b1, 40, t2);
      wait_until(1, 1'b1, 40, t3);
      chk("t2_cur_tooth", t1 - ta, 10);
      chk("t2_next_tooth", t2 - t1, 20);
      chk("t2_after_tooth", t3 - t2, 20);
      disable_run();
      repeat (2) @(negedge clk);
      m_on = 1'b1;

      // HIGH clipped to P-1
      bus_write(BASE + 8'd4, 16'd50);
      bus_write(BASE + 8'd1, 16'd10);
      bus_write(BASE + 8'd2, 16'd0);
      set_cfg(10, 50, 6, 2, 0);
      enable_run();
      hi = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i < 10) hi += int'(wheel_out);
      end
      chk("t4_high_clip", hi, 9);
      disable_run();

      // period 1 behaves as 2
      bus_write(BASE + 8'd1, 16'd1);
      bus_write(BASE + 8'd2, 16'd0);
      set_cfg(1, 50, 6, 2, 0);
      enable_run();
      hi = 0; th = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         hi += int'(wheel_out); th += int'(tooth_stb);
      end
      chk("t4_p2_teeth", th, 6);
      chk("t4_p2_high", hi, 4);
      disable_run();

      // N=2, M=2 is invalid: EN does not start the wheel
      bus_write(BASE + 8'd3, 16'h0202);
      bus_write(BASE, 16'h0001);
      repeat (20) @(negedge clk);
      chk("t4_invalid_running", running, 0);
      chk("t4_invalid_wheel", wheel_out, 0);
      read_chk("t4_invalid_stat", BASE + 8'd5, 16'h0000);
      bus_write(BASE, 16'h0000);

      // inverted default 60-2 wheel
      bus_write(BASE + 8'd3, 16'h023C);
      bus_write(BASE + 8'd1, 16'd100);
      bus_write(BASE + 8'd2, 16'd0);
      bus_write(BASE + 8'd4, 16'd8);
      m_on = 1'b0;
      bus_write(BASE, 16'h0002);
      set_cfg(100, 8, 60, 2, 1);
      repeat (2) @(negedge clk);
      m_on = 1'b1;
      enable_run();
      hi = 0; th = 0; rv = 0; t1 = 0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         hi += int'(!wheel_out); th += int'(tooth_stb); rv += int'(rev_stb);
         if (i >= 5800) t1 += int'(wheel_out);
      end
      chk("t5_low_cycles", hi, 464);
      chk("t5_teeth", th, 60);
      chk("t5_revs", rv, 1);
      chk("t5_gap_high", t1, 200);

      // reset during an active (low) pulse
      wait_until(0, 1'b0, 200, ta);
      m_on = 1'b0;
      #1 rst = 1'b0;
      #1;
      chk("t5_rst_wheel", wheel_out, 0);
      chk("t5_rst_tooth", tooth_stb, 0);
      chk("t5_rst_rev", rev_stb, 0);
      chk("t5_rst_running", running, 0);
      @(negedge clk);
      rst = 1'b1;
      read_chk("t5_rst_ctrl", BASE, 16'h0000);
      read_chk("t5_rst_teeth", BASE + 8'd3, 16'h023C);
      set_cfg(100, 8, 60, 2, 0);
      m_stop = 0;
      m_on   = 1'b1;
      repeat (5) @(negedge clk);
      m_on = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
